ahb_arbiter_param: RTL and testbench
====================================

AHB_ARBITER_PARAM -- requirements
Module: ahb_arbiter_param

Interface
REQ-001 Parameter N_MASTERS, default 16, number of bus masters (2..16).
REQ-002 Parameter DEFAULT_MASTER, default 0, master granted at reset and when no eligible request exists.
REQ-003 Parameter ARB_MODE, default ARB_RR, arbitration policy: ARB_FIXED (lowest index wins) or ARB_RR (round-robin).
REQ-004 Port HCLK  input  1  bus clock; all state updates on rising edge.
REQ-005 Port HRESETn  input  1  reset, synchronous, active-low.
REQ-006 Port HBUSREQx  input  N_MASTERS  per-master bus request.
REQ-007 Port HLOCKx  input  N_MASTERS  per-master locked-transfer request.
REQ-008 Port HSPLIT  input  N_MASTERS  split-release strobes from slaves, bit i releases master i.
REQ-009 Port HRESP  input  2  slave response; 2'b11 = SPLIT.
REQ-010 Port HREADY  input  1  transfer-complete.
REQ-011 Port HGRANTx  output  N_MASTERS  registered one-hot grant.
REQ-012 Port HMASTER  output  $clog2(N_MASTERS)  index of master owning the address phase.
REQ-013 Port HMASTLOCK  output  1  current address phase is locked.

Function
REQ-014 HGRANTx SHALL be exactly one-hot in every cycle after reset.
REQ-015 Eligible master i: HBUSREQx[i]=1 and split_mask[i]=0.
REQ-016 Re-arbitration SHALL occur on a rising edge only when HREADY=1 and HLOCKx[g]=0, g = currently granted index; otherwise HGRANTx holds.
REQ-017 ARB_FIXED: new grant = lowest eligible index.
REQ-018 ARB_RR: search starts at (last_winner+1) mod N_MASTERS, wraps, last_winner updated only when a requesting master wins.
REQ-019 No eligible master: grant DEFAULT_MASTER, even if DEFAULT_MASTER is split-masked; last_winner unchanged.
REQ-020 Granted master still eligible at re-arbitration in ARB_RR SHALL lose to any other eligible master; wins again only if alone.
REQ-021 HMASTER SHALL load index(HGRANTx) on each edge with HREADY=1 (one-cycle lag from grant); hold otherwise.
REQ-022 HMASTLOCK SHALL load HLOCKx[index(HGRANTx)] on each edge with HREADY=1; hold otherwise.
REQ-023 split_mask[HMASTER] SHALL set on an edge with HRESP=2'b11 and HREADY=0 (first SPLIT cycle).
REQ-024 split_mask[i] SHALL clear on an edge with HSPLIT[i]=1; simultaneous set and clear of same bit: set wins.
REQ-025 A split-masked master holding the grant SHALL lose it at the next re-arbitration opportunity.
REQ-026 Inputs are sampled only; no combinational path from any input to any output.

Reset
REQ-027 On rising HCLK with HRESETn=0: HGRANTx = one-hot DEFAULT_MASTER, HMASTER = DEFAULT_MASTER, HMASTLOCK = 0, split_mask = 0, last_winner = DEFAULT_MASTER.
REQ-028 Reset asserted mid-transfer or mid-lock SHALL override all other updates in that cycle; no state survives.

Structure
REQ-029 Package ahb_arb_pkg SHALL hold enum arb_mode_e {ARB_FIXED, ARB_RR}, constant HRESP_SPLIT = 2'b11 and the HRESP encodings.
REQ-030 Sub-module ahb_arb_pick (combinational, parametrised by N_MASTERS) SHALL compute winner index and valid flag from eligible vector and start index; fixed mode uses start index 0.
REQ-031 Concurrent assertions SHALL check one-hot grant, grant stability while locked and no grant to a split-masked master while another master is eligible.

Verification (N_MASTERS=4, DEFAULT_MASTER=0, HREADY=1 unless stated)
REQ-032 Reset release, HBUSREQx=0 -> HGRANTx=4'b0001, HMASTER=0, HMASTLOCK=0.
REQ-033 ARB_RR, HBUSREQx=4'b1111 held for 8 cycles -> grant sequence 1,2,3,0,1,2,3,0; ARB_FIXED same stimulus -> grant 0 constantly.
REQ-034 Master 2 granted with HLOCKx[2]=1, HBUSREQx=4'b1111, 5 cycles -> HGRANTx=4'b0100 held, HMASTLOCK=1 from the next HREADY edge; HLOCKx[2]=0 -> grant moves to 3.
REQ-035 HMASTER=1, HRESP=SPLIT with HREADY=0 then 1, HBUSREQx=4'b0010 -> master 1 masked, grant goes to 0; HSPLIT=4'b0010 one cycle -> master 1 re-granted at next arbitration.
REQ-036 HREADY=0 for 3 cycles with HBUSREQx changing -> HGRANTx, HMASTER and HMASTLOCK unchanged; HREADY=1 -> normal arbitration resumes.
REQ-037 HRESETn=0 for one cycle during a locked transfer by master 3 -> HGRANTx=4'b0001, HMASTLOCK=0, split_mask=0 on that edge.

Source files
------------

// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the parametrised AHB bus arbiter.
package ahb_arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

endpackage

// File: rtl/ahb_arb_pick.sv
// Circular first-set search: returns the first eligible index at or after start, wrapping.
module ahb_arb_pick #(
    parameter int unsigned  N_MASTERS = 16,
    localparam int unsigned IW        = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] eligible,
    input  logic [IW-1:0]        start,
    output logic [IW-1:0]        winner,
    output logic                 valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int unsigned off = 0; off < N_MASTERS; off++) begin
            idx = IW'((32'(start) + off) % N_MASTERS);
            if (!valid && eligible[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_param.sv
// AHB arbiter with fixed-priority or round-robin policy, lock hold and SPLIT masking.
module ahb_arbiter_param
    import ahb_arb_pkg::*;
#(
    parameter int unsigned  N_MASTERS      = 16,
    parameter int unsigned  DEFAULT_MASTER = 0,
    parameter arb_mode_e    ARB_MODE       = ARB_RR,
    localparam int unsigned IW             = $clog2(N_MASTERS)
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [N_MASTERS-1:0] HBUSREQx,
    input  logic [N_MASTERS-1:0] HLOCKx,
    input  logic [N_MASTERS-1:0] HSPLIT,
    input  logic [1:0]           HRESP,
    input  logic                 HREADY,
    output logic [N_MASTERS-1:0] HGRANTx,
    output logic [IW-1:0]        HMASTER,
    output logic                 HMASTLOCK
);

    localparam logic [IW-1:0]        DefIdx    = IW'(DEFAULT_MASTER);
    localparam logic [N_MASTERS-1:0] OneHotLsb = N_MASTERS'(1);

    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [N_MASTERS-1:0] split_mask_q, split_mask_d;
    logic [N_MASTERS-1:0] eligible, pick_elig, split_set;
    logic [IW-1:0]        grant_idx_q, grant_idx_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        hmaster_q;
    logic [IW-1:0]        rr_start, pick_start, pick_idx, win_idx;
    logic                 hmastlock_q;
    logic                 pick_valid, win_valid, rearb;

    assign eligible = HBUSREQx & ~split_mask_q;
    assign rearb    = HREADY && !HLOCKx[grant_idx_q];
    assign rr_start = (32'(last_q) == N_MASTERS - 1) ? '0 : last_q + IW'(1);

    // In round-robin the current owner is excluded so any other requester beats it.
    assign pick_elig  = (ARB_MODE == ARB_RR) ? (eligible & ~grant_q) : eligible;
    assign pick_start = (ARB_MODE == ARB_RR) ? rr_start : '0;

    ahb_arb_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_pick (
        .eligible (pick_elig),
        .start    (pick_start),
        .winner   (pick_idx),
        .valid    (pick_valid)
    );

    always_comb begin
        win_idx   = pick_idx;
        win_valid = pick_valid;
        if (ARB_MODE == ARB_RR && !pick_valid && eligible[grant_idx_q]) begin
            win_idx   = grant_idx_q;
            win_valid = 1'b1;
        end
    end

    always_comb begin
        grant_idx_d = grant_idx_q;
        last_d      = last_q;
        if (rearb) begin
            if (win_valid) begin
                grant_idx_d = win_idx;
                last_d      = win_idx;
            end else begin
                grant_idx_d = DefIdx;
            end
        end
        grant_d = OneHotLsb << grant_idx_d;
    end

    always_comb begin
        split_set = '0;
        if (HRESP == HRESP_SPLIT && !HREADY) begin
            split_set[hmaster_q] = 1'b1;
        end
        // Set wins over a simultaneous release of the same master.
        split_mask_d = (split_mask_q & ~HSPLIT) | split_set;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q      <= OneHotLsb << DefIdx;
            grant_idx_q  <= DefIdx;
            last_q       <= DefIdx;
            hmaster_q    <= DefIdx;
            hmastlock_q  <= 1'b0;
            split_mask_q <= '0;
        end else begin
            grant_q      <= grant_d;
            grant_idx_q  <= grant_idx_d;
            last_q       <= last_d;
            split_mask_q <= split_mask_d;
            if (HREADY) begin
                hmaster_q   <= grant_idx_q;
                hmastlock_q <= HLOCKx[grant_idx_q];
            end
        end
    end

    assign HGRANTx   = grant_q;
    assign HMASTER   = hmaster_q;
    assign HMASTLOCK = hmastlock_q;

    a_grant_onehot: assert property (@(posedge HCLK) disable iff (!HRESETn)
        $onehot(grant_q));

    a_grant_locked_stable: assert property (@(posedge HCLK) disable iff (!HRESETn)
        HLOCKx[grant_idx_q] |=> $stable(grant_q));

    a_no_grant_to_masked: assert property (@(posedge HCLK) disable iff (!HRESETn)
        (rearb && |eligible) |-> eligible[grant_idx_d]);

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// Directed and random checks of both arbitration policies against a behavioural model.
module tb_ahb_arbiter_param;
    import ahb_arb_pkg::*;

    localparam int N = 4;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] busreq, hlock, hsplit;
    logic [1:0] hresp;
    logic       hready;

    logic [3:0] gnt_f, gnt_r;
    logic [1:0] hm_f, hm_r;
    logic       ml_f, ml_r;

    int errors = 0;
    int checks = 0;

    // Behavioural model state, index 0 = fixed priority, 1 = round robin.
    int       m_g[2];
    int       m_last[2];
    int       m_hm[2];
    bit       m_lock[2];
    bit [3:0] m_mask[2];

    always #5 HCLK = ~HCLK;

    ahb_arbiter_param #(
        .N_MASTERS      (N),
        .DEFAULT_MASTER (0),
        .ARB_MODE       (ARB_FIXED)
    ) u_fix (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQx  (busreq),
        .HLOCKx    (hlock),
        .HSPLIT    (hsplit),
        .HRESP     (hresp),
        .HREADY    (hready),
        .HGRANTx   (gnt_f),
        .HMASTER   (hm_f),
        .HMASTLOCK (ml_f)
    );

    ahb_arbiter_param #(
        .N_MASTERS      (N),
        .DEFAULT_MASTER (0),
        .ARB_MODE       (ARB_RR)
    ) u_rr (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HBUSREQx  (busreq),
        .HLOCKx    (hlock),
        .HSPLIT    (hsplit),
        .HRESP     (hresp),
        .HREADY    (hready),
        .HGRANTx   (gnt_r),
        .HMASTER   (hm_r),
        .HMASTLOCK (ml_r)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int       ng;
            int       nl;
            bit [3:0] elig;
            bit       found;
            if (!HRESETn) begin
                m_g[k]    = 0;
                m_last[k] = 0;
                m_hm[k]   = 0;
                m_lock[k] = 1'b0;
                m_mask[k] = '0;
            end else begin
                elig  = busreq & ~m_mask[k];
                ng    = m_g[k];
                nl    = m_last[k];
                found = 1'b0;
                if (hready && !hlock[m_g[k]]) begin
                    if (k == 0) begin
                        for (int i = 0; i < N; i++)
                            if (!found && elig[i]) begin found = 1'b1; ng = i; end
                    end else begin
                        for (int off = 1; off <= N; off++) begin
                            int c;
                            c = (m_last[k] + off) % N;
                            if (!found && elig[c] && c != m_g[k]) begin found = 1'b1; ng = c; end
                        end
                        if (!found && elig[m_g[k]]) begin found = 1'b1; ng = m_g[k]; end
                    end
                    if (found) nl = ng;
                    else ng = 0;
                end
                m_mask[k] = m_mask[k] & ~hsplit;
                if (hresp == 2'b11 && !hready) m_mask[k][m_hm[k]] = 1'b1;
                if (hready) begin
                    m_hm[k]   = m_g[k];
                    m_lock[k] = hlock[m_g[k]];
                end
                m_g[k]    = ng;
                m_last[k] = nl;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge HCLK);
        #1;
        chk({tag, " fix grant"}, 32'(gnt_f), 32'(1) << m_g[0]);
        chk({tag, " fix hmaster"}, 32'(hm_f), 32'(m_hm[0]));
        chk({tag, " fix hmastlock"}, 32'(ml_f), 32'(m_lock[0]));
        chk({tag, " rr grant"}, 32'(gnt_r), 32'(1) << m_g[1]);
        chk({tag, " rr hmaster"}, 32'(hm_r), 32'(m_hm[1]));
        chk({tag, " rr hmastlock"}, 32'(ml_r), 32'(m_lock[1]));
    endtask

    initial begin
        int seq[8];
        seq = '{1, 2, 3, 0, 1, 2, 3, 0};
        HRESETn = 1'b0;
        busreq  = '0;
        hlock   = '0;
        hsplit  = '0;
        hresp   = 2'b00;
        hready  = 1'b1;
        tick("reset");
        tick("reset");

        HRESETn = 1'b1;
        tick("release");
        chk("release grant", 32'(gnt_r), 32'h1);
        chk("release hmaster", 32'(hm_r), 32'h0);
        chk("release hmastlock", 32'(ml_r), 32'h0);

        busreq = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick("allreq");
            chk("rr sequence", 32'(gnt_r), 32'(1) << seq[i]);
            chk("fixed constant", 32'(gnt_f), 32'h1);
        end

        busreq = 4'b0100;
        tick("to m2");
        chk("grant m2", 32'(gnt_r), 32'h4);
        hlock  = 4'b0100;
        busreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick("locked");
            chk("lock grant held", 32'(gnt_r), 32'h4);
            chk("lock hmastlock", 32'(ml_r), 32'h1);
        end
        hlock = 4'b0000;
        tick("unlock");
        chk("unlock grant m3", 32'(gnt_r), 32'h8);

        busreq = 4'b0010;
        tick("to m1");
        tick("m1 addr");
        chk("m1 hmaster", 32'(hm_r), 32'h1);
        hresp  = 2'b11;
        hready = 1'b0;
        tick("split1");
        chk("split1 grant held", 32'(gnt_r), 32'h2);
        hready = 1'b1;
        tick("split2");
        chk("split masked default", 32'(gnt_r), 32'h1);
        hresp  = 2'b00;
        hsplit = 4'b0010;
        tick("release split");
        hsplit = 4'b0000;
        tick("regrant");
        chk("regrant m1", 32'(gnt_r), 32'h2);

        hready = 1'b0;
        busreq = 4'b1111;
        tick("wait a");
        busreq = 4'b0101;
        tick("wait b");
        busreq = 4'b1000;
        tick("wait c");
        chk("wait grant", 32'(gnt_r), 32'h2);
        chk("wait hmaster", 32'(hm_r), 32'h0);
        chk("wait hmastlock", 32'(ml_r), 32'h0);
        hready = 1'b1;
        tick("resume");
        chk("resume grant m3", 32'(gnt_r), 32'h8);

        hlock = 4'b1000;
        tick("m3 lock");
        chk("m3 hmastlock", 32'(ml_r), 32'h1);
        chk("m3 hmaster", 32'(hm_r), 32'h3);
        hresp  = 2'b11;
        hready = 1'b0;
        tick("m3 split");
        chk("m3 split mask", 32'(u_rr.split_mask_q), 32'h8);
        HRESETn = 1'b0;
        hresp   = 2'b00;
        hready  = 1'b1;
        tick("mid reset");
        chk("mid reset grant", 32'(gnt_r), 32'h1);
        chk("mid reset hmastlock", 32'(ml_r), 32'h0);
        chk("mid reset hmaster", 32'(hm_r), 32'h0);
        chk("mid reset mask", 32'(u_rr.split_mask_q), 32'h0);
        HRESETn = 1'b1;
        hlock   = '0;
        busreq  = '0;
        tick("post reset");

        for (int i = 0; i < 400; i++) begin
            busreq  = 4'($urandom);
            hlock   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            hsplit  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            hresp   = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
            hready  = ($urandom_range(0, 4) != 0);
            HRESETn = ($urandom_range(0, 60) != 0);
            tick("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
